// File: rtl/rvfi_trace_pkg.sv
// +------------------------------------------------------------------+
// | rvfi_trace_pkg : shared types for the RVFI retirement trace path |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package rvfi_trace_pkg;

  localparam int unsigned ORDER_W    = 32;
  localparam int unsigned MODE_W     = 2;
  localparam int unsigned TRACE_XLEN = 32;

  typedef struct packed {
    logic [ORDER_W-1:0]    order;
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] next_pc;
    logic [31:0]           insn;
    logic [4:0]            rd_addr;
    logic [TRACE_XLEN-1:0] rd_wdata;
    logic [MODE_W-1:0]     mode;
`ifdef RVFI_TRACE_MEM_EN
    logic [TRACE_XLEN-1:0] mem_addr;
    logic [TRACE_XLEN-1:0] mem_rdata;
    logic [TRACE_XLEN-1:0] mem_wdata;
`endif
  } trace_entry_t;

  // x0 is hard-wired to zero, so whatever the core reports for it is meaningless
  function automatic logic [TRACE_XLEN-1:0] mask_rd_wdata(input logic [4:0]            rd,
                                                         input logic [TRACE_XLEN-1:0] wd);
    return (rd == 5'd0) ? '0 : wd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvfi_trace_buffer_fifo.sv
// +------------------------------------------------------------------+
// | trace_fifo : generic first-word-fall-through FIFO                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             w_push, w_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  assign wr_ptr_d = wr_ptr_q + PW'(w_push);
  assign rd_ptr_d = rd_ptr_q + PW'(w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/rvfi_trace_buffer.sv
// +------------------------------------------------------------------+
// | rvfi_trace_buffer : order-stamped RVFI retirement FIFO with drop |
// | accounting. Optional macro RVFI_TRACE_MEM_EN adds memory fields. |
// | XLEN must equal rvfi_trace_pkg::TRACE_XLEN.       Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module rvfi_trace_buffer
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned XLEN   = TRACE_XLEN,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rvfi_valid_i,
  input  logic [XLEN-1:0]        rvfi_pc_rdata_i,
  input  logic [XLEN-1:0]        rvfi_pc_wdata_i,
  input  logic [31:0]            rvfi_insn_i,
  input  logic [4:0]             rvfi_rd_addr_i,
  input  logic [XLEN-1:0]        rvfi_rd_wdata_i,
  input  logic [MODE_W-1:0]      rvfi_mode_i,
`ifdef RVFI_TRACE_MEM_EN
  input  logic [XLEN-1:0]        rvfi_mem_addr_i,
  input  logic [XLEN-1:0]        rvfi_mem_rdata_i,
  input  logic [XLEN-1:0]        rvfi_mem_wdata_i,
  output logic [XLEN-1:0]        trace_mem_addr_o,
  output logic [XLEN-1:0]        trace_mem_rdata_o,
  output logic [XLEN-1:0]        trace_mem_wdata_o,
`endif
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [ORDER_W-1:0]     trace_order_o,
  output logic [XLEN-1:0]        trace_pc_o,
  output logic [XLEN-1:0]        trace_next_pc_o,
  output logic [31:0]            trace_insn_o,
  output logic [4:0]             trace_rd_addr_o,
  output logic [XLEN-1:0]        trace_rd_wdata_o,
  output logic [MODE_W-1:0]      trace_mode_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [DROP_W-1:0]      drop_count_o,
  input  logic                   clear_status_i
);

  logic [ORDER_W-1:0] order_q, order_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;

  logic               w_full, w_empty, w_push, w_pop, w_drop;
  trace_entry_t       w_wr_entry, w_head, w_out;

  assign w_pop  = !w_empty && trace_ready_i;
  assign w_push = rvfi_valid_i && (!w_full || w_pop);
  assign w_drop = rvfi_valid_i && w_full && !w_pop;

  always_comb begin
    w_wr_entry          = '0;
    w_wr_entry.order    = order_q;
    w_wr_entry.pc       = rvfi_pc_rdata_i;
    w_wr_entry.next_pc  = rvfi_pc_wdata_i;
    w_wr_entry.insn     = rvfi_insn_i;
    w_wr_entry.rd_addr  = rvfi_rd_addr_i;
    w_wr_entry.rd_wdata = mask_rd_wdata(rvfi_rd_addr_i, rvfi_rd_wdata_i);
    w_wr_entry.mode     = rvfi_mode_i;
`ifdef RVFI_TRACE_MEM_EN
    w_wr_entry.mem_addr  = rvfi_mem_addr_i;
    w_wr_entry.mem_rdata = rvfi_mem_rdata_i;
    w_wr_entry.mem_wdata = rvfi_mem_wdata_i;
`endif
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_wr_entry),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  // Order advances on every retirement, stored or not, so sink-side gaps expose drops
  always_comb begin
    order_d      = order_q + ORDER_W'(rvfi_valid_i);
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear_status_i) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (w_drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != {DROP_W{1'b1}}) begin
        drop_count_d = drop_count_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      order_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      order_q      <= order_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage is not reset; masking on empty keeps idle outputs at zero
  assign w_out = w_empty ? '0 : w_head;

  assign trace_valid_o    = !w_empty;
  assign trace_order_o    = w_out.order;
  assign trace_pc_o       = w_out.pc;
  assign trace_next_pc_o  = w_out.next_pc;
  assign trace_insn_o     = w_out.insn;
  assign trace_rd_addr_o  = w_out.rd_addr;
  assign trace_rd_wdata_o = w_out.rd_wdata;
  assign trace_mode_o     = w_out.mode;
`ifdef RVFI_TRACE_MEM_EN
  assign trace_mem_addr_o  = w_out.mem_addr;
  assign trace_mem_rdata_o = w_out.mem_rdata;
  assign trace_mem_wdata_o = w_out.mem_wdata;
`endif
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_rvfi_trace_buffer.sv
// +------------------------------------------------------------------+
// | tb_rvfi_trace_buffer : queue-model bench for rvfi_trace_buffer   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_rvfi_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [31:0] rvfi_pc = '0, rvfi_npc = '0, rvfi_insn = '0, rvfi_wd = '0;
  logic [4:0]  rvfi_rd = '0;
  logic [1:0]  rvfi_mode = '0;
  logic        trace_ready = 1'b0;
  logic        clear_status = 1'b0;

  logic        trace_valid;
  logic [31:0] trace_order, trace_pc, trace_npc, trace_insn, trace_wd;
  logic [4:0]  trace_rd;
  logic [1:0]  trace_mode;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
`ifdef RVFI_TRACE_MEM_EN
  logic [31:0] rvfi_ma = '0, rvfi_mr = '0, rvfi_mw = '0;
  logic [31:0] trace_ma, trace_mr, trace_mw;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rvfi_trace_buffer #(.DEPTH(DEPTH), .XLEN(32), .DROP_W(16)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .rvfi_valid_i     (rvfi_valid),
    .rvfi_pc_rdata_i  (rvfi_pc),
    .rvfi_pc_wdata_i  (rvfi_npc),
    .rvfi_insn_i      (rvfi_insn),
    .rvfi_rd_addr_i   (rvfi_rd),
    .rvfi_rd_wdata_i  (rvfi_wd),
    .rvfi_mode_i      (rvfi_mode),
`ifdef RVFI_TRACE_MEM_EN
    .rvfi_mem_addr_i  (rvfi_ma),
    .rvfi_mem_rdata_i (rvfi_mr),
    .rvfi_mem_wdata_i (rvfi_mw),
    .trace_mem_addr_o (trace_ma),
    .trace_mem_rdata_o(trace_mr),
    .trace_mem_wdata_o(trace_mw),
`endif
    .trace_valid_o    (trace_valid),
    .trace_ready_i    (trace_ready),
    .trace_order_o    (trace_order),
    .trace_pc_o       (trace_pc),
    .trace_next_pc_o  (trace_npc),
    .trace_insn_o     (trace_insn),
    .trace_rd_addr_o  (trace_rd),
    .trace_rd_wdata_o (trace_wd),
    .trace_mode_o     (trace_mode),
    .level_o          (level),
    .overflow_o       (overflow),
    .drop_count_o     (drop_count),
    .clear_status_i   (clear_status)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of what the sink should still see
  typedef struct {
    logic [31:0] order, pc, npc, insn, wd;
    logic [4:0]  rd;
    logic [1:0]  mode;
`ifdef RVFI_TRACE_MEM_EN
    logic [31:0] ma, mr, mw;
`endif
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_order = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_order <= '0;
      m_ovf   <= 1'b0;
      m_drop  <= '0;
    end else begin : model_step
      bit   was_full, popped;
      ent_t e;
      was_full = (mq.size() == DEPTH);
      popped   = (mq.size() != 0) && trace_ready;
      if (popped) mq.delete(0);
      if (rvfi_valid) begin
        if (!was_full || popped) begin
          e.order = m_order;  e.pc = rvfi_pc;   e.npc = rvfi_npc; e.insn = rvfi_insn;
          e.rd    = rvfi_rd;  e.mode = rvfi_mode;
          e.wd    = (rvfi_rd == 5'd0) ? 32'd0 : rvfi_wd;
`ifdef RVFI_TRACE_MEM_EN
          e.ma = rvfi_ma; e.mr = rvfi_mr; e.mw = rvfi_mw;
`endif
          mq.push_back(e);
        end else if (!clear_status) begin
          m_ovf <= 1'b1;
          if (m_drop != 16'hFFFF) m_drop <= m_drop + 16'd1;
        end
        m_order <= m_order + 32'd1;
      end
      if (clear_status) begin
        m_ovf  <= 1'b0;
        m_drop <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 64'(trace_valid), 64'(mq.size() != 0));
      chk("level", 64'(level), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (mq.size() != 0) begin
        chk("head_order", 64'(trace_order), 64'(mq[0].order));
        chk("head_pc", {trace_pc, trace_npc}, {mq[0].pc, mq[0].npc});
        chk("head_insn", 64'(trace_insn), 64'(mq[0].insn));
        chk("head_rd", {25'd0, trace_rd, trace_wd, trace_mode}, {25'd0, mq[0].rd, mq[0].wd, mq[0].mode});
`ifdef RVFI_TRACE_MEM_EN
        chk("head_mem", {trace_ma, trace_mr ^ trace_mw}, {mq[0].ma, mq[0].mr ^ mq[0].mw});
`endif
      end else begin
        chk("idle_zero", 64'(|{trace_order, trace_pc, trace_npc, trace_insn, trace_rd, trace_wd, trace_mode}), 64'd0);
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] pc, input logic [4:0] rd,
                     input logic [31:0] wd, input bit rdy, input bit clr);
    rvfi_valid = v;  rvfi_pc = pc;  rvfi_npc = pc + 32'd4;
    rvfi_insn = pc ^ 32'h0000_0013;  rvfi_rd = rd;  rvfi_wd = wd;
    rvfi_mode = pc[3:2];  trace_ready = rdy;  clear_status = clr;
`ifdef RVFI_TRACE_MEM_EN
    rvfi_ma = pc ^ 32'h0000_1000;  rvfi_mr = ~pc;  rvfi_mw = pc + 32'd1;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("lit_reset_valid", 64'(trace_valid), 64'd0);
    chk("lit_reset_level", 64'(level), 64'd0);

    // Three retirements streaming straight through
    cyc(1, 32'h0, 5'd1, 32'h11, 1, 0);
    chk("lit_s1_order0", {31'd0, trace_valid, trace_order}, {31'd0, 1'b1, 32'd0});
    cyc(1, 32'h4, 5'd2, 32'h22, 1, 0);
    chk("lit_s1_order1", {trace_pc, trace_order}, {32'h4, 32'd1});
    cyc(1, 32'h8, 5'd3, 32'h33, 1, 0);
    chk("lit_s1_order2", {trace_pc, trace_order}, {32'h8, 32'd2});
    cyc(0, 0, 0, 0, 1, 0);
    chk("lit_s1_empty", {63'd0, trace_valid}, 64'd0);

    // Back-pressure: 20 retirements into 16 slots
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 32'h100 + 32'(4 * i), 5'd1, 32'(i), 0, 0);
    chk("lit_s2_level", 64'(level), 64'd16);
    chk("lit_s2_ovf_drop", {47'd0, overflow, drop_count}, {47'd0, 1'b1, 16'd4});
    for (int i = 0; i < 16; i++) begin
      chk("lit_s2_drain_order", 64'(trace_order), 64'(i));
      cyc(0, 0, 0, 0, 1, 0);
    end
    cyc(1, 32'h200, 5'd2, 32'h7, 0, 0);
    chk("lit_s2_next_order", 64'(trace_order), 64'd20);
    for (int i = 0; i < 15; i++) cyc(1, 32'h204 + 32'(4 * i), 5'd3, 32'(i), 0, 0);
    chk("lit_s2_refull", 64'(level), 64'd16);
    cyc(1, 32'h300, 5'd4, 32'h9, 1, 0);
    chk("lit_s2_fullpp", {level, drop_count, trace_order}, {5'd16, 16'd4, 32'd21});

    // x0 write-back masking
    do_reset();
    cyc(1, 32'h300, 5'd0, 32'hDEADBEEF, 0, 0);
    chk("lit_rd0_wdata", {27'd0, trace_rd, trace_wd}, 64'd0);
    cyc(1, 32'h304, 5'd5, 32'h12345678, 1, 0);
    chk("lit_rd5_wdata", {27'd0, trace_rd, trace_wd}, {27'd0, 5'd5, 32'h12345678});
    cyc(0, 0, 0, 0, 1, 0);

    // Drop counter saturation and status clear
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 32'(4 * i), 5'd1, 32'(i), 0, 0);
    for (int i = 0; i < 32'h10000; i++) cyc(1, 32'h1000, 5'd1, 32'd1, 0, 0);
    chk("lit_sat", {47'd0, overflow, drop_count}, {47'd0, 1'b1, 16'hFFFF});
    cyc(1, 32'h1000, 5'd1, 32'd1, 0, 1);
    chk("lit_clear_wins", {47'd0, overflow, drop_count}, 64'd0);
    cyc(1, 32'h1000, 5'd1, 32'd1, 0, 0);
    chk("lit_drop_after_clear", {47'd0, overflow, drop_count}, {47'd0, 1'b1, 16'd1});
    cyc(0, 0, 0, 0, 0, 1);
    chk("lit_clear", {47'd0, overflow, drop_count}, 64'd0);

    // Asynchronous reset mid-drain
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 32'h500 + 32'(4 * i), 5'd6, 32'(i), 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("lit_rst_pre_level", 64'(level), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_async", {58'd0, trace_valid, level}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 32'h600, 5'd7, 32'h77, 0, 0);
    chk("lit_rst_order", {31'd0, trace_valid, trace_order}, {31'd0, 1'b1, 32'd0});
    cyc(0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rvfi_trace_buffer.md
Name: rvfi_trace_buffer

Overview:
- Consumes the core's RVFI retirement outputs (valid, PC, instruction, register write-back, mode) directly downstream of the core/memory top.
- Stamps each retirement with a monotonic order number and buffers it in a FIFO.
- Drains entries over a valid/ready stream to a trace sink (UART formatter or bench scoreboard).
- Counts and flags entries lost when the sink back-pressures.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
XLEN, 32, data/address width
DROP_W, 16, width of saturating drop counter

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
rvfi_valid  in  1  one instruction retired this cycle
rvfi_pc_rdata  in  XLEN  PC of retired instruction
rvfi_pc_wdata  in  XLEN  next PC
rvfi_insn  in  32  instruction word
rvfi_rd_addr  in  5  destination register
rvfi_rd_wdata  in  XLEN  write-back data
rvfi_mode  in  2  privilege mode
trace_valid  out  1  entry available at head
trace_ready  in  1  sink accepts head entry
trace_order  out  32  retirement sequence number
trace_pc  out  XLEN  head PC
trace_next_pc  out  XLEN  head next PC
trace_insn  out  32  head instruction
trace_rd_addr  out  5  head rd
trace_rd_wdata  out  XLEN  head write-back data
trace_mode  out  2  head mode
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one entry dropped
drop_count  out  DROP_W  saturating count of dropped retirements
clear_status  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (reset low, async):
  - FIFO empty, level=0, trace_valid=0.
  - Order counter=0, overflow=0, drop_count=0.
  - All trace_* data outputs 0.
- Push:
  - A push occurs when rvfi_valid=1 and the FIFO is not full, or when the FIFO is full and a pop occurs the same cycle.
  - Each pushed entry captures the inputs plus the current order value.
- Order counter:
  - Increments on every rvfi_valid=1 cycle, whether or not the entry is stored.
  - Gaps in trace_order therefore identify drops.
  - Wraps modulo 2^32.
- rd_addr == 0: the stored rd_wdata is forced to 0 regardless of input.
- Pop: trace_valid && trace_ready. Pop on empty is impossible, since trace_valid=0 when empty; trace_ready is ignored.
- Output style: first-word-fall-through.
  - The head entry is presented combinationally from the storage read at rd_ptr.
  - An entry pushed in cycle N is visible with trace_valid=1 in cycle N+1.
  - trace_* outputs are stable while trace_valid=1 and trace_ready=0.
- Full with rvfi_valid=1 and no pop:
  - Entry dropped; no FIFO state changes.
  - overflow set to 1.
  - drop_count += 1, saturating at all-ones.
- Simultaneous push and pop: level unchanged, both pointers advance. This holds when full (entry accepted) and when level=1 (new entry becomes head next cycle).
- Pointers are $clog2(DEPTH)+1 bits:
  - full when the MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
  - Wrap-around is natural binary.
- clear_status=1:
  - overflow=0 and drop_count=0 next cycle.
  - If a drop occurs in the same cycle, clear wins and the order gap remains.
  - clear_status does not affect FIFO contents or the order counter.
- Reset asserted mid-stream: all contents discarded immediately; trace_valid falls asynchronously.

Optional Feature:
- Macro: RVFI_TRACE_MEM_EN.
- When defined:
  - Adds inputs rvfi_mem_addr/rvfi_mem_rdata/rvfi_mem_wdata (XLEN each).
  - Adds matching outputs trace_mem_addr/trace_mem_rdata/trace_mem_wdata, stored per entry with identical timing.
  - Entry width grows by 3*XLEN.
- When undefined: these ports do not exist and storage excludes them.

Decomposition:
- Package rvfi_trace_pkg:
  - trace_entry_t packed struct (order, pc, next_pc, insn, rd_addr, rd_wdata, mode, and mem fields under RVFI_TRACE_MEM_EN).
  - Localparams ORDER_W=32 and MODE_W=2.
- Sub-module trace_fifo:
  - Generic synchronous FWFT FIFO parameterised by DEPTH and entry type/width.
  - Interface: push/pop/full/empty/level.
- Top handles order counter, rd_addr-0 masking, drop/overflow logic and status clear.

Test Plan:
- Reset, then 3 retirements (pc 0x0, 0x4, 0x8; trace_ready=1) -> 3 entries with order 0, 1, 2; each trace_valid one cycle after its rvfi_valid; level returns to 0.
- trace_ready=0 with DEPTH=16 and 20 retirements -> level=16, overflow=1, drop_count=4; draining yields orders 0..15; next retirement gets order 20.
- FIFO full, rvfi_valid=1 and trace_ready=1 in the same cycle -> no drop, level stays 16, drop_count unchanged.
- Retire with rd_addr=0 and rd_wdata=0xDEADBEEF -> trace_rd_wdata=0.
- Force 0x10000 drops with DROP_W=16 -> drop_count saturates at 0xFFFF; clear_status pulse -> overflow=0, drop_count=0 next cycle.
- Assert reset with level=5 mid-drain -> trace_valid=0 immediately; after release the next retirement has order 0.
